// File: rtl/contrast_stage.sv
// contrast_stage: debounced two-key gain control (0..15, unity 8) and a 2-stage per-channel contrast pipeline.
// Build option CONTRAST_REPEAT_EN adds auto-repeat stepping while a key stays pressed.

module contrast_key #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_key_n,
    output logic o_step
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
        $error("contrast_key: DEBOUNCE_CYCLES and REPEAT_CYCLES must be at least 2");
    end

    logic          r_sync1, r_sync2, r_deb, r_step;
    logic [DW-1:0] r_deb_cnt;
    logic          w_differ, w_flip, w_rep_fire;

    assign w_differ = (r_sync2 != r_deb);
    assign w_flip   = w_differ && (r_deb_cnt == DW'(DEBOUNCE_CYCLES - 1));

`ifdef CONTRAST_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    logic [RW-1:0] r_rep_cnt;

    assign w_rep_fire = !r_deb && (r_rep_cnt == RW'(REPEAT_CYCLES - 1));

    // Runs only while the debounced state is pressed; release clears it.
    always_ff @(posedge clk) begin
        if (reset || r_deb || w_rep_fire)
            r_rep_cnt <= '0;
        else
            r_rep_cnt <= r_rep_cnt + RW'(1);
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_deb     <= 1'b1;
            r_deb_cnt <= '0;
            r_step    <= 1'b0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            // A flip while currently released is a debounced press.
            r_step  <= (w_flip && r_deb) || w_rep_fire;
            if (w_flip) begin
                r_deb     <= ~r_deb;
                r_deb_cnt <= '0;
            end else if (w_differ) begin
                r_deb_cnt <= r_deb_cnt + DW'(1);
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

    assign o_step = r_step;
endmodule

module contrast_stage #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
    input  logic       key_up,
    input  logic       key_dn,
    output logic       out_valid,
    output logic [7:0] r_out,
    output logic [7:0] g_out,
    output logic [7:0] b_out,
    output logic [3:0] level
);
    logic w_up, w_dn;

    contrast_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_key_up (
        .clk(clk), .reset(reset), .i_key_n(key_up), .o_step(w_up)
    );
    contrast_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_key_dn (
        .clk(clk), .reset(reset), .i_key_n(key_dn), .o_step(w_dn)
    );

    logic [3:0] r_level;

    always_ff @(posedge clk) begin
        if (reset)
            r_level <= 4'd8;
        else if (w_up && !w_dn && r_level != 4'd15)
            r_level <= r_level + 4'd1;
        else if (w_dn && !w_up && r_level != 4'd0)
            r_level <= r_level - 4'd1;
    end

    logic        [7:0]  w_pix   [3];
    logic signed [12:0] w_d     [3];
    logic signed [12:0] w_p     [3];
    logic signed [12:0] w_y     [3];
    logic        [7:0]  w_clamp [3];
    logic signed [12:0] r_p     [3];
    logic        [7:0]  r_y     [3];
    logic               r_v1, r_v2;

    assign w_pix[0] = r_in;
    assign w_pix[1] = g_in;
    assign w_pix[2] = b_in;

    // 13 bits covers -128*15 .. 127*15; the shift floors toward -inf.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            w_d[c] = $signed({5'b0, w_pix[c]}) - 13'sd128;
            w_p[c] = w_d[c] * $signed({9'b0, r_level});
            w_y[c] = 13'sd128 + (r_p[c] >>> 3);
            if (w_y[c][12])
                w_clamp[c] = 8'd0;
            else if (w_y[c] > 13'sd255)
                w_clamp[c] = 8'd255;
            else
                w_clamp[c] = w_y[c][7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                r_p[c] <= '0;
                r_y[c] <= '0;
            end
        end else begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            for (int c = 0; c < 3; c++) begin
                if (in_valid) r_p[c] <= w_p[c];
                if (r_v1)     r_y[c] <= w_clamp[c];
            end
        end
    end

    assign out_valid = r_v2;
    assign r_out     = r_y[0];
    assign g_out     = r_y[1];
    assign b_out     = r_y[2];
    assign level     = r_level;
endmodule

// File: tb/tb_contrast_stage.sv
// Directed self-checking bench for contrast_stage with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_contrast_stage;
    logic       clk = 1'b0;
    logic       reset, in_valid, key_up, key_dn;
    logic [7:0] r_in, g_in, b_in;
    logic       out_valid;
    logic [7:0] r_out, g_out, b_out;
    logic [3:0] level;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    contrast_stage #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .key_up(key_up), .key_dn(key_dn),
        .out_valid(out_valid), .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .level(level)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic px(input logic v, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        in_valid = v;
        r_in = r;
        g_in = g;
        b_in = b;
    endtask

    task automatic chk_px(input string tag, input logic v, input logic [7:0] r,
                          input logic [7:0] g, input logic [7:0] b);
        chk({tag, "_valid"}, {7'b0, out_valid}, {7'b0, v});
        chk({tag, "_r"}, r_out, r);
        chk({tag, "_g"}, g_out, g);
        chk({tag, "_b"}, b_out, b);
    endtask

    task automatic press(input bit up, input bit dn);
        if (up) key_up = 1'b0;
        if (dn) key_dn = 1'b0;
        tick(7);
        key_up = 1'b1;
        key_dn = 1'b1;
        tick(12);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        key_up = 1'b1;
        key_dn = 1'b1;
        px(1'b0, 8'd0, 8'd0, 8'd0);
        tick(3);
        reset = 1'b0;
        chk("rst_level", {4'b0, level}, 8'd8);
        chk_px("rst_out", 1'b0, 8'd0, 8'd0, 8'd0);

        // identity at level 8, with gaps
        px(1'b1, 8'd0, 8'd255, 8'd0);
        tick(1);
        px(1'b1, 8'd100, 8'd155, 8'd100);
        tick(1);
        chk_px("id0", 1'b1, 8'd0, 8'd255, 8'd0);
        px(1'b0, 8'd55, 8'd55, 8'd55);
        tick(1);
        chk_px("id100", 1'b1, 8'd100, 8'd155, 8'd100);
        px(1'b1, 8'd200, 8'd55, 8'd200);
        tick(1);
        chk_px("id_gap", 1'b0, 8'd100, 8'd155, 8'd100);
        px(1'b1, 8'd255, 8'd0, 8'd255);
        tick(1);
        chk_px("id200", 1'b1, 8'd200, 8'd55, 8'd200);
        px(1'b0, 8'd0, 8'd0, 8'd0);
        tick(1);
        chk_px("id255", 1'b1, 8'd255, 8'd0, 8'd255);
        tick(1);
        chk_px("id_tail", 1'b0, 8'd255, 8'd0, 8'd255);

        // 3-cycle glitch: no step
        key_up = 1'b0;
        tick(3);
        key_up = 1'b1;
        tick(12);
        chk("glitch_level", {4'b0, level}, 8'd8);

        // stable press: level changes on edge 7
        key_up = 1'b0;
        tick(6);
        chk("deb_edge6", {4'b0, level}, 8'd8);
        tick(1);
        chk("deb_edge7", {4'b0, level}, 8'd9);
        key_up = 1'b1;
        tick(12);
        chk("deb_release", {4'b0, level}, 8'd9);

        // down to level 4, gain math
        for (int i = 0; i < 5; i++) press(1'b0, 1'b1);
        chk("dn_to4", {4'b0, level}, 8'd4);
        px(1'b1, 8'd200, 8'd100, 8'd128);
        tick(1);
        px(1'b1, 8'd100, 8'd200, 8'd0);
        tick(1);
        px(1'b0, 8'd0, 8'd0, 8'd0);
        chk_px("g4_a", 1'b1, 8'd164, 8'd114, 8'd128);
        tick(1);
        chk_px("g4_b", 1'b1, 8'd114, 8'd164, 8'd64);

        // up to saturation at 15
        for (int i = 0; i < 13; i++) press(1'b1, 1'b0);
        chk("up_sat15", {4'b0, level}, 8'd15);
        press(1'b1, 1'b1);
        chk("both_at15", {4'b0, level}, 8'd15);
        px(1'b1, 8'd255, 8'd0, 8'd200);
        tick(1);
        px(1'b1, 8'd100, 8'd128, 8'd129);
        tick(1);
        px(1'b0, 8'd0, 8'd0, 8'd0);
        chk_px("g15_a", 1'b1, 8'd255, 8'd0, 8'd255);
        tick(1);
        chk_px("g15_b", 1'b1, 8'd75, 8'd128, 8'd129);

        // down to saturation at 0
        for (int i = 0; i < 20; i++) press(1'b0, 1'b1);
        chk("dn_sat0", {4'b0, level}, 8'd0);
        px(1'b1, 8'd37, 8'd255, 8'd0);
        tick(1);
        px(1'b0, 8'd0, 8'd0, 8'd0);
        tick(1);
        chk_px("g0", 1'b1, 8'd128, 8'd128, 8'd128);
        press(1'b1, 1'b0);
        chk("up_to1", {4'b0, level}, 8'd1);
        press(1'b1, 1'b1);
        chk("both_at1", {4'b0, level}, 8'd1);

        // long hold: auto-repeat only when enabled
        key_up = 1'b0;
        tick(7);
        chk("hold_first", {4'b0, level}, 8'd2);
        tick(38);
        key_up = 1'b1;
        tick(20);
`ifdef CONTRAST_REPEAT_EN
        chk("hold_repeat", {4'b0, level}, 8'd6);
`else
        chk("hold_repeat", {4'b0, level}, 8'd2);
`endif

        // reset in the middle of a continuous stream
        px(1'b1, 8'd200, 8'd100, 8'd128);
        tick(3);
`ifdef CONTRAST_REPEAT_EN
        chk_px("pre_rst", 1'b1, 8'd182, 8'd107, 8'd128);
`else
        chk_px("pre_rst", 1'b1, 8'd146, 8'd121, 8'd128);
`endif
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk_px("mid_rst1", 1'b0, 8'd0, 8'd0, 8'd0);
        chk("mid_rst_level", {4'b0, level}, 8'd8);
        tick(1);
        chk_px("mid_rst2", 1'b0, 8'd0, 8'd0, 8'd0);
        tick(1);
        chk_px("resume", 1'b1, 8'd200, 8'd100, 8'd128);
        px(1'b0, 8'd0, 8'd0, 8'd0);
        tick(2);
        chk("end_valid", {7'b0, out_valid}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
